// File: rtl/ps2_host_ctrl_if.sv
// ps2_host_ctrl_if
// Groups the byte-level handshake between the PS/2 host controller and the
// packet decoders / command issuer sitting above it.
//   txData/txValid/txReady : host-to-device command byte, valid/ready handshake
//   txDone                 : one-cycle pulse, byte sent and acknowledged
//   rxData/rxValid/rxRd    : receive FIFO head, non-empty flag, pop strobe
//   rxOvf                  : sticky, a good frame was dropped on a full FIFO
//   fail/errCode/clrErr    : sticky first-error report and its clear strobe
//   busy                   : controller is not idle
// modport master : the user of the controller
// modport slave  : the controller itself
interface ps2_host_ctrl_if;
  logic [7:0] txData;
  logic       txValid;
  logic       txReady;
  logic       txDone;
  logic [7:0] rxData;
  logic       rxValid;
  logic       rxRd;
  logic       rxOvf;
  logic       fail;
  logic [2:0] errCode;
  logic       clrErr;
  logic       busy;

  modport master (
    output txData, txValid, rxRd, clrErr,
    input  txReady, txDone, rxData, rxValid, rxOvf, fail, errCode, busy
  );

  modport slave (
    input  txData, txValid, rxRd, clrErr,
    output txReady, txDone, rxData, rxValid, rxOvf, fail, errCode, busy
  );
endinterface

// File: rtl/ps2_host_ctrl.sv
// ps2_host_ctrl
// Bidirectional PS/2 host: receives device frames into a small FIFO and sends
// host-to-device command bytes with inhibit, request-to-send and ack check.
// Both pads are open-drain (driven 0 or released) and are synchronised and
// glitch filtered before use.
// Ports:
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   ps2Clk_io  : PS/2 clock pad (open drain)
//   ps2Data_io : PS/2 data pad (open drain)
//   bus        : byte handshake, FIFO and error reporting (slave modport)
// Parameters:
//   FILT        : equal synchronised samples needed to accept a new pad level
//   INHIBIT_CYC : cycles PS2CLK is held low before a transmit
//   TIMEOUT_CYC : max cycles between device clock falling edges in a frame
//   FIFO_DEPTH  : receive FIFO entries, power of 2, >= 2
module ps2_host_ctrl #(
  parameter int FILT        = 8,
  parameter int INHIBIT_CYC = 5000,
  parameter int TIMEOUT_CYC = 100000,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  inout  wire              ps2Clk_io,
  inout  wire              ps2Data_io,
  ps2_host_ctrl_if.slave   bus
);

  localparam int FW = (FILT > 1) ? $clog2(FILT) : 1;
  localparam int IW = $clog2(INHIBIT_CYC + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] RX_BITS   = 3'd1;
  localparam logic [2:0] TX_INH    = 3'd2;
  localparam logic [2:0] TX_BITS   = 3'd3;
  localparam logic [2:0] TX_ACK    = 3'd4;
  localparam logic [2:0] WAIT_IDLE = 3'd5;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_PARITY  = 3'd1;
  localparam logic [2:0] ERR_FRAME   = 3'd2;
  localparam logic [2:0] ERR_RX_TO   = 3'd3;
  localparam logic [2:0] ERR_NO_ACK  = 3'd4;
  localparam logic [2:0] ERR_TX_TO   = 3'd5;

  // Input path registers
  logic [1:0]    clkSync_q, dataSync_q;
  logic [FW-1:0] clkCnt_q, clkCnt_d, dataCnt_q, dataCnt_d;
  logic          clkFilt_q, clkFilt_d, dataFilt_q, dataFilt_d;
  logic          clkFiltDly_q;
  logic          fallEdge;

  // Control registers
  logic [2:0]    state_q, state_d;
  logic [3:0]    bitCnt_q, bitCnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          parity_q, parity_d;
  logic [IW-1:0] inhCnt_q, inhCnt_d;
  logic [TW-1:0] toCnt_q, toCnt_d;
  logic          clkLow_q, clkLow_d;
  logic          dataLow_q, dataLow_d;
  logic          txDone_q, txDone_d;
  logic [2:0]    errCode_q, errCode_d;
  logic          rxOvf_q, rxOvf_d;
  logic          alive_q;

  // FIFO
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wrPtr_q, rdPtr_q;
  logic [CW-1:0] count_q;

  logic          pushReq;
  logic [2:0]    newErr;
  logic          timedState;
  logic          toExpired;
  logic          popEff;
  logic          fifoFull;
  logic          doPush;
  logic          drop;

  // Open-drain pads: only ever pull low or release.
  assign ps2Clk_io  = clkLow_q  ? 1'b0 : 1'bz;
  assign ps2Data_io = dataLow_q ? 1'b0 : 1'bz;

  // Filter: a level is accepted only after FILT consecutive differing samples.
  always_comb begin
    clkFilt_d = clkFilt_q;
    clkCnt_d  = '0;
    if (clkSync_q[1] != clkFilt_q) begin
      if (clkCnt_q == FW'(FILT - 1)) clkFilt_d = clkSync_q[1];
      else                           clkCnt_d  = clkCnt_q + 1'b1;
    end
    dataFilt_d = dataFilt_q;
    dataCnt_d  = '0;
    if (dataSync_q[1] != dataFilt_q) begin
      if (dataCnt_q == FW'(FILT - 1)) dataFilt_d = dataSync_q[1];
      else                            dataCnt_d  = dataCnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clkSync_q    <= 2'b11;
      dataSync_q   <= 2'b11;
      clkCnt_q     <= '0;
      dataCnt_q    <= '0;
      clkFilt_q    <= 1'b1;
      dataFilt_q   <= 1'b1;
      clkFiltDly_q <= 1'b1;
    end else begin
      clkSync_q    <= {clkSync_q[0], ps2Clk_io};
      dataSync_q   <= {dataSync_q[0], ps2Data_io};
      clkCnt_q     <= clkCnt_d;
      dataCnt_q    <= dataCnt_d;
      clkFilt_q    <= clkFilt_d;
      dataFilt_q   <= dataFilt_d;
      clkFiltDly_q <= clkFilt_q;
    end
  end

  assign fallEdge = clkFiltDly_q & ~clkFilt_q;

  // The inter-edge timer only runs while a frame is in flight.
  assign timedState = (state_q == RX_BITS) || (state_q == TX_BITS) || (state_q == TX_ACK);
  assign toExpired  = (toCnt_q == TW'(TIMEOUT_CYC - 1));

  // Main sequencer: one falling edge per bit in both directions.
  always_comb begin
    state_d   = state_q;
    bitCnt_d  = bitCnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    inhCnt_d  = inhCnt_q;
    clkLow_d  = clkLow_q;
    dataLow_d = dataLow_q;
    txDone_d  = 1'b0;
    pushReq   = 1'b0;
    newErr    = ERR_NONE;
    toCnt_d   = (timedState && !fallEdge) ? toCnt_q + 1'b1 : '0;

    case (state_q)
      IDLE: begin
        // A device clock edge beats a pending transmit request.
        if (fallEdge) begin
          if (!dataFilt_q) begin
            state_d  = RX_BITS;
            bitCnt_d = '0;
          end
        end else if (bus.txValid && alive_q) begin
          shift_d  = bus.txData;
          state_d  = TX_INH;
          clkLow_d = 1'b1;
          inhCnt_d = '0;
        end
      end

      RX_BITS: begin
        if (fallEdge) begin
          bitCnt_d = bitCnt_q + 4'd1;
          if (bitCnt_q < 4'd8) begin
            shift_d = {dataFilt_q, shift_q[7:1]};
          end else if (bitCnt_q == 4'd8) begin
            parity_d = dataFilt_q;
          end else begin
            if (^{shift_q, parity_q} == 1'b0) newErr  = ERR_PARITY;
            else if (!dataFilt_q)             newErr  = ERR_FRAME;
            else                              pushReq = 1'b1;
            state_d = WAIT_IDLE;
          end
        end else if (toExpired) begin
          newErr  = ERR_RX_TO;
          state_d = WAIT_IDLE;
        end
      end

      TX_INH: begin
        // Data goes low while the clock is still held, then the clock is
        // released: that is the request-to-send.
        inhCnt_d = inhCnt_q + 1'b1;
        if (inhCnt_q == IW'(INHIBIT_CYC - 2)) dataLow_d = 1'b1;
        if (inhCnt_q == IW'(INHIBIT_CYC - 1)) begin
          clkLow_d = 1'b0;
          state_d  = TX_BITS;
          bitCnt_d = '0;
        end
      end

      TX_BITS: begin
        if (fallEdge) begin
          bitCnt_d = bitCnt_q + 4'd1;
          if (bitCnt_q < 4'd8) begin
            dataLow_d = ~shift_q[bitCnt_q[2:0]];
          end else if (bitCnt_q == 4'd8) begin
            // Odd parity bit is 0 when the data already has an odd count.
            dataLow_d = ^shift_q;
          end else begin
            dataLow_d = 1'b0;
            state_d   = TX_ACK;
          end
        end else if (toExpired) begin
          newErr    = ERR_TX_TO;
          dataLow_d = 1'b0;
          state_d   = WAIT_IDLE;
        end
      end

      TX_ACK: begin
        if (fallEdge) begin
          if (!dataFilt_q) txDone_d = 1'b1;
          else             newErr   = ERR_NO_ACK;
          state_d = WAIT_IDLE;
        end else if (toExpired) begin
          newErr  = ERR_TX_TO;
          state_d = WAIT_IDLE;
        end
      end

      WAIT_IDLE: begin
        clkLow_d  = 1'b0;
        dataLow_d = 1'b0;
        if (clkFilt_q && dataFilt_q) state_d = IDLE;
      end

      default: begin
        state_d   = IDLE;
        clkLow_d  = 1'b0;
        dataLow_d = 1'b0;
      end
    endcase
  end

  // FIFO bookkeeping: a pop frees a slot for a push in the same cycle.
  assign popEff   = bus.rxRd && (count_q != '0);
  assign fifoFull = (count_q == CW'(FIFO_DEPTH));
  assign doPush   = pushReq && (!fifoFull || popEff);
  assign drop     = pushReq && fifoFull && !popEff;

  // First error is held; an error arriving with the clear strobe wins.
  always_comb begin
    errCode_d = errCode_q;
    if (newErr != ERR_NONE && (errCode_q == ERR_NONE || bus.clrErr)) errCode_d = newErr;
    else if (bus.clrErr)                                            errCode_d = ERR_NONE;
    rxOvf_d = rxOvf_q;
    if (drop)            rxOvf_d = 1'b1;
    else if (bus.clrErr) rxOvf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bitCnt_q  <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      inhCnt_q  <= '0;
      toCnt_q   <= '0;
      clkLow_q  <= 1'b0;
      dataLow_q <= 1'b0;
      txDone_q  <= 1'b0;
      errCode_q <= ERR_NONE;
      rxOvf_q   <= 1'b0;
      alive_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      bitCnt_q  <= bitCnt_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      inhCnt_q  <= inhCnt_d;
      toCnt_q   <= toCnt_d;
      clkLow_q  <= clkLow_d;
      dataLow_q <= dataLow_d;
      txDone_q  <= txDone_d;
      errCode_q <= errCode_d;
      rxOvf_q   <= rxOvf_d;
      alive_q   <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) begin
        mem_q[wrPtr_q] <= shift_q;
        wrPtr_q        <= wrPtr_q + 1'b1;
      end
      if (popEff) rdPtr_q <= rdPtr_q + 1'b1;
      count_q <= count_q + CW'(doPush) - CW'(popEff);
    end
  end

  assign bus.txReady = (state_q == IDLE) && !fallEdge && alive_q;
  assign bus.txDone  = txDone_q;
  assign bus.rxData  = mem_q[rdPtr_q];
  assign bus.rxValid = (count_q != '0);
  assign bus.rxOvf   = rxOvf_q;
  assign bus.errCode = errCode_q;
  assign bus.fail    = (errCode_q != ERR_NONE);
  assign bus.busy    = (state_q != IDLE);

endmodule
